// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters (CPU, DMA), the arbiter and the RAM.
// The arbiter connects through the slave modport; masters and RAM use the master modport.
interface dmem_arbiter_if;
  logic        m0_req, m1_req;
  logic        m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
    output mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: one RAM access per cycle, peripheral-region writes blocked.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise master 0 wins ties.
module dmem_arbiter #(
  parameter logic [3:0] PERIPH_TAG = 4'b0100,
  parameter int         CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic        owner;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic        last_owner;
`endif

  logic        elig0, elig1, any_elig, win;
  logic        sel_we, blocked;
  logic [31:0] sel_addr, sel_wdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The current owner is excluded so no master is granted twice in a row.
  always_comb begin
    elig0    = bus.m0_req && !(state == ACCESS && owner == 1'b0);
    elig1    = bus.m1_req && !(state == ACCESS && owner == 1'b1);
    any_elig = elig0 || elig1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    win      = (elig0 && elig1) ? ~last_owner : elig1;
`else
    win      = !elig0;
`endif
    sel_we    = win ? bus.m1_we    : bus.m0_we;
    sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    blocked   = sel_we && (sel_addr[31:28] == PERIPH_TAG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_owner    <= 1'b1;
`endif
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.rdata     <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      blk_cnt       <= '0;
    end else begin
      // Read completion: capture RAM data at the end of the ACCESS cycle.
      bus.m0_rvalid <= bus.mem_read && (owner == 1'b0);
      bus.m1_rvalid <= bus.mem_read && (owner == 1'b1);
      if (bus.mem_read)
        bus.rdata <= bus.mem_rdata;

      if (any_elig) begin
        state         <= ACCESS;
        owner         <= win;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_owner    <= win;
`endif
        bus.m0_gnt    <= !win;
        bus.m1_gnt    <= win;
        bus.mem_addr  <= sel_addr;
        bus.mem_wdata <= sel_wdata;
        bus.mem_read  <= !sel_we;
        bus.mem_write <= sel_we && !blocked;
        if (blocked)
          blk_cnt <= sat_inc(blk_cnt);
      end else begin
        state         <= IDLE;
        bus.m0_gnt    <= 1'b0;
        bus.m1_gnt    <= 1'b0;
        bus.mem_read  <= 1'b0;
        bus.mem_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16-word behavioural RAM.
// Tie expectations follow DMEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_dmem_arbiter;
  logic       clk;
  logic       reset;
  logic [7:0] blk_cnt;
  logic [31:0] ram [16];
  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter_if bus();

  dmem_arbiter #(.PERIPH_TAG(4'b0100), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .blk_cnt(blk_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign bus.mem_rdata = ram[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h1000 + i;
      ram[2] <= 32'h1234;
    end else if (bus.mem_write) begin
      ram[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
  endtask

  initial begin
    logic exp_tie_m1;
    reset = 1'b1;
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();

    check_eq("rst_gnt",     32'({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid}), 32'h0);
    check_eq("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'h0);
    check_eq("rst_addr",    bus.mem_addr, 32'h0);
    check_eq("rst_rdata",   bus.rdata, 32'h0);
    check_eq("rst_blk",     32'(blk_cnt), 32'h0);

    // Single read by m0, requested on the first edge after release
    reset = 1'b0;
    drive_m0(1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    check_eq("rd_gnt0",     32'({bus.m0_gnt, bus.m1_gnt}), 32'h2);
    check_eq("rd_mem_read", 32'({bus.mem_read, bus.mem_write}), 32'h2);
    check_eq("rd_mem_addr", bus.mem_addr, 32'h8);
    drive_m0(1'b0, 1'b0, 32'h8, 32'h0);
    tick();
    check_eq("rd_rvalid",   32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h2);
    check_eq("rd_rdata",    bus.rdata, 32'h1234);
    check_eq("rd_idle",     32'({bus.m0_gnt, bus.mem_read}), 32'h0);
    check_eq("rd_addr_hold", bus.mem_addr, 32'h8);
    tick();
    check_eq("rd_rvalid_drop", 32'(bus.m0_rvalid), 32'h0);

    // Blocked peripheral writes from m1, counter saturation
    drive_m1(1'b1, 1'b1, 32'h4000_0010, 32'hFF);
    tick();
    check_eq("blk_gnt1",    32'({bus.m0_gnt, bus.m1_gnt}), 32'h1);
    check_eq("blk_nowrite", 32'({bus.mem_read, bus.mem_write}), 32'h0);
    check_eq("blk_cnt1",    32'(blk_cnt), 32'h1);
    drive_m1(1'b0, 1'b1, 32'h4000_0010, 32'hFF);
    tick();
    check_eq("blk_norvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h0);
    check_eq("blk_rdata",    bus.rdata, 32'h1234);
    for (int i = 1; i < 300; i++) begin
      drive_m1(1'b1, 1'b1, 32'h4000_0010, 32'hFF);
      tick();
      drive_m1(1'b0, 1'b1, 32'h4000_0010, 32'hFF);
      tick();
    end
    check_eq("blk_sat", 32'(blk_cnt), 32'hFF);

    // m0 write then m1 read of the same word, back-to-back
    drive_m0(1'b1, 1'b1, 32'h4, 32'hA5A5);
    drive_m1(1'b1, 1'b0, 32'h4, 32'h0);
    tick();
    check_eq("wr_gnt0",   32'({bus.m0_gnt, bus.m1_gnt}), 32'h2);
    check_eq("wr_strobe", 32'({bus.mem_read, bus.mem_write}), 32'h1);
    check_eq("wr_wdata",  bus.mem_wdata, 32'hA5A5);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check_eq("rb_gnt1",   32'({bus.m0_gnt, bus.m1_gnt}), 32'h1);
    check_eq("rb_strobe", 32'({bus.mem_read, bus.mem_write}), 32'h2);
    drive_m1(1'b0, 1'b0, 32'h4, 32'h0);
    tick();
    check_eq("rb_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h1);
    check_eq("rb_rdata",  bus.rdata, 32'hA5A5);

    // Continuous requests from both masters alternate owners
    drive_m0(1'b1, 1'b0, 32'h8, 32'h0);
    drive_m1(1'b1, 1'b0, 32'hC, 32'h0);
    tick();
    check_eq("alt_c1", 32'({bus.m0_gnt, bus.m1_gnt}), 32'h2);
    tick();
    check_eq("alt_c2", 32'({bus.m0_gnt, bus.m1_gnt}), 32'h1);
    check_eq("alt_c2_rd", bus.rdata, 32'h1234);
    tick();
    check_eq("alt_c3", 32'({bus.m0_gnt, bus.m1_gnt}), 32'h2);
    check_eq("alt_c3_rv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h1);
    check_eq("alt_c3_rd", bus.rdata, 32'h1003);
    tick();
    check_eq("alt_c4", 32'({bus.m0_gnt, bus.m1_gnt}), 32'h1);
    drive_m0(1'b0, 1'b0, 32'h8, 32'h0);
    drive_m1(1'b0, 1'b0, 32'hC, 32'h0);
    tick();
    check_eq("alt_idle", 32'({bus.m0_gnt, bus.m1_gnt, bus.mem_read, bus.mem_write}), 32'h0);

    // Tie after m0 was the last owner
    drive_m0(1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    check_eq("solo_gnt0", 32'({bus.m0_gnt, bus.m1_gnt}), 32'h2);
    drive_m0(1'b0, 1'b0, 32'h8, 32'h0);
    tick();
    drive_m0(1'b1, 1'b0, 32'h8, 32'h0);
    drive_m1(1'b1, 1'b0, 32'hC, 32'h0);
    tick();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_tie_m1 = 1'b1;
`else
    exp_tie_m1 = 1'b0;
`endif
    check_eq("tie_policy", 32'({bus.m0_gnt, bus.m1_gnt}), 32'({~exp_tie_m1, exp_tie_m1}));
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset in the middle of a read ACCESS cycle
    drive_m0(1'b1, 1'b0, 32'hC, 32'h0);
    tick();
    check_eq("ra_mem_read", 32'(bus.mem_read), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_eq("ra_abort",  32'({bus.mem_read, bus.m0_gnt, bus.m0_rvalid}), 32'h0);
    check_eq("ra_rdata",  bus.rdata, 32'h0);
    check_eq("ra_blk",    32'(blk_cnt), 32'h0);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("ra_norvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h0);
    drive_m1(1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    check_eq("ra_regrant", 32'({bus.m1_gnt, bus.mem_read}), 32'h3);
    drive_m1(1'b0, 1'b0, 32'h8, 32'h0);
    tick();
    check_eq("ra_rv1",    32'(bus.m1_rvalid), 32'h1);
    check_eq("ra_rdata2", bus.rdata, 32'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
